// File: rtl/ex_wb_collector.sv
`default_nettype none
// ============================================================================
// Module   : ex_wb_collector
// Brief    : EX result collector. Registers the two EX lanes onto the two
//            register-file write ports and fills idle ports from a 2-entry
//            buffer of long-latency results (divider, multicycle FPU).
// Revision : 1.0 - initial release
// ============================================================================
module ex_wb_collector #(
    parameter int DATA_W     = 64,
    parameter int RD_W       = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid_0,
    input  logic [RD_W-1:0]   ex_rd_0,
    input  logic [DATA_W-1:0] ex_data_0,
    input  logic              ex_valid_1,
    input  logic [RD_W-1:0]   ex_rd_1,
    input  logic [DATA_W-1:0] ex_data_1,
    input  logic              simd_ena,
    input  logic              lr_valid,
    input  logic [RD_W-1:0]   lr_rd,
    input  logic [DATA_W-1:0] lr_data,
    output logic              lr_ready,
    output logic              wb_we_0,
    output logic [RD_W-1:0]   wb_rd_0,
    output logic [DATA_W-1:0] wb_data_0,
    output logic              wb_we_1,
    output logic [RD_W-1:0]   wb_rd_1,
    output logic [DATA_W-1:0] wb_data_1
);

    localparam logic [1:0] c_FULL = 2'(FIFO_DEPTH);

    // Buffer storage: slot index is the pointer value (depth 2, 1-bit pointers)
    logic [RD_W-1:0]   r_entRd   [2];
    logic [DATA_W-1:0] r_entData [2];
    logic [1:0]        r_entVld;
    logic              r_rdPtr;
    logic              r_wrPtr;
    logic [1:0]        r_count;
    logic              r_lrReady;

    logic              r_wbWe0, r_wbWe1;
    logic [RD_W-1:0]   r_wbRd0, r_wbRd1;
    logic [DATA_W-1:0] r_wbData0, r_wbData1;

    logic              w_lane0We, w_lane1We;
    logic              w_hdIdx, w_sdIdx;
    logic              w_aPresent, w_bPresent;
    logic              w_aKill, w_bKill;
    logic              w_aLive, w_bLive;
    logic              w_deqA, w_deqB;
    logic              w_aPort0, w_aPort1, w_bPort0, w_bPort1;
    logic              w_invalidateB;
    logic              w_enq;
    logic [1:0]        w_countNext;
    logic              w_p0We, w_p1We;
    logic [RD_W-1:0]   w_p0Rd, w_p1Rd;
    logic [DATA_W-1:0] w_p0Data, w_p1Data;

    // Narrow mode keeps only the low 32 bits of any written value
    function automatic logic [DATA_W-1:0] fitWidth(input logic [DATA_W-1:0] d, input logic full);
        fitWidth = full ? d : {{(DATA_W-32){1'b0}}, d[31:0]};
    endfunction

    // Lane 1 is younger, so on a same-rd collision lane 0 is dropped
    assign w_lane1We = ex_valid_1 && (ex_rd_1 != '0);
    assign w_lane0We = ex_valid_0 && (ex_rd_0 != '0) && !(w_lane1We && (ex_rd_1 == ex_rd_0));

    assign w_hdIdx    = r_rdPtr;
    assign w_sdIdx    = ~r_rdPtr;
    assign w_aPresent = (r_count != 2'd0);
    assign w_bPresent = (r_count == c_FULL);

    // A buffered entry is stale when a younger EX lane writes its rd this cycle
    assign w_aKill = (w_lane0We && (r_entRd[w_hdIdx] == ex_rd_0)) ||
                     (w_lane1We && (r_entRd[w_hdIdx] == ex_rd_1));
    assign w_bKill = (w_lane0We && (r_entRd[w_sdIdx] == ex_rd_0)) ||
                     (w_lane1We && (r_entRd[w_sdIdx] == ex_rd_1));
    assign w_aLive = w_aPresent && r_entVld[w_hdIdx] && !w_aKill;
    assign w_bLive = w_bPresent && r_entVld[w_sdIdx] && !w_bKill;

    // Drain arbitration: dead heads are skipped at no cost, live entries fill idle ports
    always_comb begin
        w_deqA        = 1'b0;
        w_deqB        = 1'b0;
        w_aPort0      = 1'b0;
        w_aPort1      = 1'b0;
        w_bPort0      = 1'b0;
        w_bPort1      = 1'b0;
        w_invalidateB = 1'b0;
        if (!flush && w_aPresent) begin
            if (!w_aLive) begin
                // Head is dead: drop it and let the second entry act as head
                w_deqA = 1'b1;
                if (w_bPresent) begin
                    if (!w_bLive) begin
                        w_deqB = 1'b1;
                    end else if (!w_lane0We) begin
                        w_deqB   = 1'b1;
                        w_bPort0 = 1'b1;
                    end else if (!w_lane1We) begin
                        w_deqB   = 1'b1;
                        w_bPort1 = 1'b1;
                    end
                end
            end else begin
                if (!w_lane0We) begin
                    w_deqA   = 1'b1;
                    w_aPort0 = 1'b1;
                end else if (!w_lane1We) begin
                    w_deqA   = 1'b1;
                    w_aPort1 = 1'b1;
                end
                // Second entry needs both ports and a distinct rd to avoid a same-cycle double write
                if (w_bPresent && w_bKill) begin
                    w_invalidateB = 1'b1;
                end else if (w_bLive && !w_lane0We && !w_lane1We &&
                             (r_entRd[w_sdIdx] != r_entRd[w_hdIdx])) begin
                    w_deqB   = 1'b1;
                    w_bPort1 = 1'b1;
                end
            end
        end
    end

    // Results for rd 0 complete the handshake but are never stored
    assign w_enq       = lr_valid && r_lrReady && !flush && (lr_rd != '0);
    assign w_countNext = r_count + 2'(w_enq) - 2'(w_deqA) - 2'(w_deqB);

    // Write-port source selection: EX lane first, then buffered result
    always_comb begin
        w_p0We   = w_lane0We || w_aPort0 || w_bPort0;
        w_p0Rd   = ex_rd_0;
        w_p0Data = ex_data_0;
        if (!w_lane0We && w_aPort0) begin
            w_p0Rd   = r_entRd[w_hdIdx];
            w_p0Data = r_entData[w_hdIdx];
        end else if (!w_lane0We && w_bPort0) begin
            w_p0Rd   = r_entRd[w_sdIdx];
            w_p0Data = r_entData[w_sdIdx];
        end
        w_p1We   = w_lane1We || w_aPort1 || w_bPort1;
        w_p1Rd   = ex_rd_1;
        w_p1Data = ex_data_1;
        if (!w_lane1We && w_aPort1) begin
            w_p1Rd   = r_entRd[w_hdIdx];
            w_p1Data = r_entData[w_hdIdx];
        end else if (!w_lane1We && w_bPort1) begin
            w_p1Rd   = r_entRd[w_sdIdx];
            w_p1Data = r_entData[w_sdIdx];
        end
    end

    // Buffer control state: count, pointers, valid bits and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 2'd0;
            r_rdPtr   <= 1'b0;
            r_wrPtr   <= 1'b0;
            r_entVld  <= 2'b00;
            r_lrReady <= 1'b1;
        end else if (flush) begin
            r_count   <= 2'd0;
            r_rdPtr   <= 1'b0;
            r_wrPtr   <= 1'b0;
            r_entVld  <= 2'b00;
            r_lrReady <= 1'b1;
        end else begin
            r_count   <= w_countNext;
            r_rdPtr   <= r_rdPtr ^ (w_deqA ^ w_deqB);
            r_wrPtr   <= r_wrPtr ^ w_enq;
            r_lrReady <= (w_countNext < c_FULL);
            if (w_invalidateB) begin
                r_entVld[w_sdIdx] <= 1'b0;
            end
            if (w_enq) begin
                r_entVld[r_wrPtr] <= 1'b1;
            end
        end
    end

    // Buffer payload; presence is tracked by count and valid bits, so no reset needed
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entRd[r_wrPtr]   <= lr_rd;
            r_entData[r_wrPtr] <= lr_data;
        end
    end

    // Registered write ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbWe0   <= 1'b0;
            r_wbRd0   <= '0;
            r_wbData0 <= '0;
            r_wbWe1   <= 1'b0;
            r_wbRd1   <= '0;
            r_wbData1 <= '0;
        end else begin
            r_wbWe0   <= w_p0We;
            r_wbRd0   <= w_p0Rd;
            r_wbData0 <= fitWidth(w_p0Data, simd_ena);
            r_wbWe1   <= w_p1We;
            r_wbRd1   <= w_p1Rd;
            r_wbData1 <= fitWidth(w_p1Data, simd_ena);
        end
    end

    assign lr_ready  = r_lrReady;
    assign wb_we_0   = r_wbWe0;
    assign wb_rd_0   = r_wbRd0;
    assign wb_data_0 = r_wbData0;
    assign wb_we_1   = r_wbWe1;
    assign wb_rd_1   = r_wbRd1;
    assign wb_data_1 = r_wbData1;

endmodule
`default_nettype wire

// File: tb/tb_ex_wb_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_wb_collector
// Brief    : Self-checking bench for ex_wb_collector: directed scenarios with
//            literal expectations plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_wb_collector;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ex_valid_0, ex_valid_1;
    logic [4:0]  ex_rd_0, ex_rd_1;
    logic [63:0] ex_data_0, ex_data_1;
    logic        simd_ena;
    logic        lr_valid;
    logic [4:0]  lr_rd;
    logic [63:0] lr_data;
    logic        lr_ready;
    logic        wb_we_0, wb_we_1;
    logic [4:0]  wb_rd_0, wb_rd_1;
    logic [63:0] wb_data_0, wb_data_1;

    ex_wb_collector #(.DATA_W(64), .RD_W(5), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid_0(ex_valid_0), .ex_rd_0(ex_rd_0), .ex_data_0(ex_data_0),
        .ex_valid_1(ex_valid_1), .ex_rd_1(ex_rd_1), .ex_data_1(ex_data_1),
        .simd_ena(simd_ena),
        .lr_valid(lr_valid), .lr_rd(lr_rd), .lr_data(lr_data), .lr_ready(lr_ready),
        .wb_we_0(wb_we_0), .wb_rd_0(wb_rd_0), .wb_data_0(wb_data_0),
        .wb_we_1(wb_we_1), .wb_rd_1(wb_rd_1), .wb_data_1(wb_data_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          mReady;
    bit          haveExp;
    bit          eWe0, eWe1, eReady;
    logic [4:0]  eRd0, eRd1;
    logic [63:0] eD0, eD1;
    int          tests;
    int          fails;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] fit(input logic [63:0] d);
        fit = simd_ena ? d : {32'h0, d[31:0]};
    endfunction

    task automatic putPort(input int p, input logic [4:0] rd, input logic [63:0] d);
        if (p == 0) begin
            eWe0 = 1'b1; eRd0 = rd; eD0 = fit(d);
        end else begin
            eWe1 = 1'b1; eRd1 = rd; eD1 = fit(d);
        end
    endtask

    // Reference: what the ports must show after the coming edge, from current inputs
    task automatic modelStep();
        bit         l0, l1, bothFree, atHead, stall, dead;
        int         freeP[$];
        int         deq;
        logic [4:0] firstRd;
        l1 = ex_valid_1 && (ex_rd_1 != 5'd0);
        l0 = ex_valid_0 && (ex_rd_0 != 5'd0) && !(l1 && ex_rd_1 == ex_rd_0);
        eWe0 = l0; eRd0 = ex_rd_0; eD0 = fit(ex_data_0);
        eWe1 = l1; eRd1 = ex_rd_1; eD1 = fit(ex_data_1);
        if (flush) begin
            q.delete();
        end else begin
            if (!l0) freeP.push_back(0);
            if (!l1) freeP.push_back(1);
            bothFree = (freeP.size() == 2);
            atHead = 1'b1; stall = 1'b0; deq = 0; firstRd = 5'd0;
            for (int i = 0; i < q.size(); i++) begin
                dead = !q[i].live || (l0 && q[i].rd == ex_rd_0) || (l1 && q[i].rd == ex_rd_1);
                if (dead) begin
                    if (atHead) deq++;
                    else q[i].live = 1'b0;
                end else if (atHead) begin
                    atHead = 1'b0;
                    if (freeP.size() > 0) begin
                        putPort(freeP.pop_front(), q[i].rd, q[i].data);
                        firstRd = q[i].rd;
                        deq++;
                    end else begin
                        stall = 1'b1;
                    end
                end else if (!stall && bothFree && freeP.size() > 0 && q[i].rd != firstRd) begin
                    putPort(freeP.pop_front(), q[i].rd, q[i].data);
                    deq++;
                end else begin
                    stall = 1'b1;
                end
            end
            repeat (deq) q.delete(0);
            if (lr_valid && mReady && lr_rd != 5'd0) q.push_back('{lr_rd, lr_data, 1'b1});
        end
        mReady = (q.size() < 2);
        eReady = mReady;
    endtask

    task automatic compareAll();
        chk("we0", {63'h0, wb_we_0}, {63'h0, eWe0});
        chk("we1", {63'h0, wb_we_1}, {63'h0, eWe1});
        chk("lr_ready", {63'h0, lr_ready}, {63'h0, eReady});
        if (eWe0 && wb_we_0) begin
            chk("rd0", {59'h0, wb_rd_0}, {59'h0, eRd0});
            chk("data0", wb_data_0, eD0);
        end
        if (eWe1 && wb_we_1) begin
            chk("rd1", {59'h0, wb_rd_1}, {59'h0, eRd1});
            chk("data1", wb_data_1, eD1);
        end
    endtask

    // One clock: check the previous expectation, predict the next, then step past the edge
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            q.delete();
            mReady  = 1'b1;
            haveExp = 1'b0;
        end else begin
            if (haveExp) compareAll();
            modelStep();
            haveExp = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; simd_ena = 1;
        ex_valid_0 = 0; ex_rd_0 = 0; ex_data_0 = 0;
        ex_valid_1 = 0; ex_rd_1 = 0; ex_data_1 = 0;
        lr_valid = 0; lr_rd = 0; lr_data = 0;
    endtask

    task automatic lanesBusy();
        ex_valid_0 = 1; ex_rd_0 = 5'd1; ex_data_0 = 64'h100;
        ex_valid_1 = 1; ex_rd_1 = 5'd2; ex_data_1 = 64'h200;
    endtask

    task automatic pushTwo(input logic [4:0] rdA, input logic [63:0] dA,
                           input logic [4:0] rdB, input logic [63:0] dB);
        lanesBusy();
        lr_valid = 1; lr_rd = rdA; lr_data = dA;
        tick();
        lr_rd = rdB; lr_data = dB;
        tick();
        lr_valid = 0;
    endtask

    initial begin
        tests = 0; fails = 0;
        q.delete(); mReady = 1'b1; haveExp = 1'b0;
        idle();
        rst = 1;
        tick(); tick(); tick();
        rst = 0;
        chk("reset_we0", {63'h0, wb_we_0}, 64'h0);
        chk("reset_we1", {63'h0, wb_we_1}, 64'h0);
        chk("reset_lr_ready", {63'h0, lr_ready}, 64'h1);

        // Lane 0 full-width write
        ex_valid_0 = 1; ex_rd_0 = 5'd3; ex_data_0 = 64'h1111_2222_3333_4444;
        tick();
        chk("lane0_we", {63'h0, wb_we_0}, 64'h1);
        chk("lane0_rd", {59'h0, wb_rd_0}, 64'd3);
        chk("lane0_data", wb_data_0, 64'h1111_2222_3333_4444);
        chk("lane0_we1", {63'h0, wb_we_1}, 64'h0);

        // Narrow mode clears the upper half
        simd_ena = 0;
        tick();
        chk("narrow_data", wb_data_0, 64'h0000_0000_3333_4444);
        simd_ena = 1;

        // Same-cycle WAW, then rd 0 on both lanes
        ex_valid_0 = 1; ex_rd_0 = 5'd7; ex_data_0 = 64'd5;
        ex_valid_1 = 1; ex_rd_1 = 5'd7; ex_data_1 = 64'd9;
        tick();
        chk("waw_we0", {63'h0, wb_we_0}, 64'h0);
        chk("waw_we1", {63'h0, wb_we_1}, 64'h1);
        chk("waw_rd1", {59'h0, wb_rd_1}, 64'd7);
        chk("waw_data1", wb_data_1, 64'd9);
        ex_rd_0 = 5'd0; ex_rd_1 = 5'd0;
        tick();
        chk("rd0_we0", {63'h0, wb_we_0}, 64'h0);
        chk("rd0_we1", {63'h0, wb_we_1}, 64'h0);

        // Fill buffer under busy lanes, then dual drain
        idle();
        chk("pre_fill_ready", {63'h0, lr_ready}, 64'h1);
        pushTwo(5'd10, 64'hA0A0, 5'd11, 64'hB0B0);
        chk("full_ready", {63'h0, lr_ready}, 64'h0);
        tick(); tick();
        idle();
        tick();
        chk("drain_we0", {63'h0, wb_we_0}, 64'h1);
        chk("drain_rd0", {59'h0, wb_rd_0}, 64'd10);
        chk("drain_data0", wb_data_0, 64'hA0A0);
        chk("drain_we1", {63'h0, wb_we_1}, 64'h1);
        chk("drain_rd1", {59'h0, wb_rd_1}, 64'd11);
        chk("drain_data1", wb_data_1, 64'hB0B0);
        chk("drain_ready", {63'h0, lr_ready}, 64'h1);

        // Stale kill of the second entry by lane 1
        pushTwo(5'd12, 64'hC0C0, 5'd13, 64'hD0D0);
        idle();
        ex_valid_1 = 1; ex_rd_1 = 5'd13; ex_data_1 = 64'h77;
        tick();
        chk("kill_we0", {63'h0, wb_we_0}, 64'h1);
        chk("kill_rd0", {59'h0, wb_rd_0}, 64'd12);
        chk("kill_data0", wb_data_0, 64'hC0C0);
        chk("kill_rd1", {59'h0, wb_rd_1}, 64'd13);
        chk("kill_data1", wb_data_1, 64'h77);
        idle();
        tick();
        chk("killed_we0", {63'h0, wb_we_0}, 64'h0);
        chk("killed_we1", {63'h0, wb_we_1}, 64'h0);
        tick();
        chk("killed_empty_we0", {63'h0, wb_we_0}, 64'h0);
        chk("killed_empty_ready", {63'h0, lr_ready}, 64'h1);

        // Flush drops buffered and incoming results; lane write survives
        pushTwo(5'd14, 64'hE0E0, 5'd15, 64'hF0F0);
        idle();
        flush = 1; lr_valid = 1; lr_rd = 5'd16; lr_data = 64'h1616;
        ex_valid_0 = 1; ex_rd_0 = 5'd4; ex_data_0 = 64'h44;
        tick();
        chk("flush_we0", {63'h0, wb_we_0}, 64'h1);
        chk("flush_rd0", {59'h0, wb_rd_0}, 64'd4);
        chk("flush_we1", {63'h0, wb_we_1}, 64'h0);
        chk("flush_ready", {63'h0, lr_ready}, 64'h1);
        idle();
        tick();
        chk("post_flush_we0", {63'h0, wb_we_0}, 64'h0);
        chk("post_flush_we1", {63'h0, wb_we_1}, 64'h0);

        // Asynchronous reset while draining
        pushTwo(5'd20, 64'h2020, 5'd21, 64'h2121);
        idle();
        tick();
        chk("pre_rst_we0", {63'h0, wb_we_0}, 64'h1);
        #2 rst = 1;
        #1;
        chk("async_rst_we0", {63'h0, wb_we_0}, 64'h0);
        chk("async_rst_we1", {63'h0, wb_we_1}, 64'h0);
        chk("async_rst_ready", {63'h0, lr_ready}, 64'h1);
        tick();
        rst = 0;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            flush      = ($urandom_range(0, 19) == 0);
            simd_ena   = ($urandom_range(0, 3) != 0);
            ex_valid_0 = $urandom_range(0, 1);
            ex_rd_0    = 5'($urandom_range(0, 7));
            ex_data_0  = {$urandom, $urandom};
            ex_valid_1 = $urandom_range(0, 1);
            ex_rd_1    = 5'($urandom_range(0, 7));
            ex_data_1  = {$urandom, $urandom};
            lr_valid   = $urandom_range(0, 1);
            lr_rd      = 5'($urandom_range(0, 7));
            lr_data    = {$urandom, $urandom};
            tick();
        end
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
